// File: rtl/decoder_ctrl_pkg.sv
// Shared definitions for the decoder round controller.
// Contents: round FSM state type and fixed phase lengths.
package decoder_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StOffer,
    StStop,
    StDrain,
    StReadout
  } ctrl_state_e;

  // Cycles the PE match registers need after stop_offer before readout.
  localparam int unsigned DrainCycles  = 2;
  // Idle cycles between the measurement load and the first offer cycle.
  localparam int unsigned SettleCycles = 1;
  // Wide enough for the longer of the two fixed phases.
  localparam int unsigned PhaseW       = 2;

endpackage

// File: rtl/quiescence_detector.sv
// Counts consecutive cycles in which no PE has an outgoing link valid.
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset
//   link_busy_i     per-PE busy flags; any set bit restarts the count
//   enable_i        count this cycle
//   clear_i         force the count back to zero
//   quiet_o         the count reaches QuietCycles in this cycle (combinational)
module quiescence_detector #(
  parameter int unsigned NumPe       = 6,
  parameter int unsigned QuietCycles = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [NumPe-1:0] link_busy_i,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic             quiet_o
);

  localparam int unsigned CntW = $clog2(QuietCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      if (|link_busy_i) begin
        cnt_d = '0;
      end else if (cnt_q != CntW'(QuietCycles)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Looks at the updated count so the FSM can leave on the cycle the run completes.
  assign quiet_o = enable_i && !clear_i && (cnt_d == CntW'(QuietCycles));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_round_controller.sv
// Sequences one decoding round of the PE grid: load syndrome, run the offer phase
// until the mesh goes quiet (or times out), stop, drain, then stream every PE's
// match value out in row-major order over valid/ready.
// Optional feature macro: ROUND_CYCLE_COUNTER_EN adds round_cycles_o.
// Ports:
//   clk_i, reset_i                    clock, synchronous active-high reset
//   syn_valid_i/syn_ready_o/syn_data_i  syndrome input handshake (bit k = PE k)
//   meas_value_o, meas_valid_o        measurement broadcast to the PEs
//   start_offer_o, stop_offer_o       offer-phase control pulses
//   link_busy_i                       per-PE outgoing link activity
//   match_i                           PE k match value at [k*W +: W]
//   res_valid_o/res_ready_i           result stream handshake
//   res_index_o, res_value_o, res_last_o  beat contents
//   busy_o                            round in progress
//   timeout_err_o                     sticky: last offer phase timed out
//   round_cycles_o                    (optional) accept-to-last-beat cycle count
module decoder_round_controller
  import decoder_ctrl_pkg::*;
#(
  parameter int unsigned GridRows        = 2,
  parameter int unsigned GridCols        = 3,
  parameter int unsigned MatchValueWidth = 8,
  parameter int unsigned QuietCycles     = 4,
  // Must be at least QuietCycles + 1.
  parameter int unsigned MaxOfferCycles  = 1024,
  localparam int unsigned NumPe          = GridRows * GridCols,
  localparam int unsigned IdxW           = (NumPe > 1) ? $clog2(NumPe) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             syn_valid_i,
  output logic                             syn_ready_o,
  input  logic [NumPe-1:0]                 syn_data_i,
  output logic [NumPe-1:0]                 meas_value_o,
  output logic                             meas_valid_o,
  output logic                             start_offer_o,
  output logic                             stop_offer_o,
  input  logic [NumPe-1:0]                 link_busy_i,
  input  logic [NumPe*MatchValueWidth-1:0] match_i,
  output logic                             res_valid_o,
  input  logic                             res_ready_i,
  output logic [IdxW-1:0]                  res_index_o,
  output logic [MatchValueWidth-1:0]       res_value_o,
  output logic                             res_last_o,
  output logic                             busy_o,
  output logic                             timeout_err_o
`ifdef ROUND_CYCLE_COUNTER_EN
  ,
  output logic [31:0]                      round_cycles_o
`endif
);

  localparam int unsigned OfferW = $clog2(MaxOfferCycles + 1);

  ctrl_state_e                state_q, state_d;
  logic [PhaseW-1:0]          phase_q, phase_d;
  logic [OfferW-1:0]          offer_q, offer_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [NumPe-1:0]           meas_value_q, meas_value_d;
  logic [MatchValueWidth-1:0] res_value_q, res_value_d;
  logic                       timeout_q, timeout_d;
  logic                       syn_ready_q, meas_valid_q, start_offer_q, stop_offer_q;
  logic                       res_valid_q, res_last_q, busy_q;
  logic                       accept, beat, quiet;

  assign accept = syn_valid_i & syn_ready_q;
  assign beat   = res_valid_q & res_ready_i;

  // The start_offer cycle is excluded from the quiet run.
  quiescence_detector #(
    .NumPe      (NumPe),
    .QuietCycles(QuietCycles)
  ) u_quiet (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .link_busy_i(link_busy_i),
    .enable_i   ((state_q == StOffer) && !start_offer_q),
    .clear_i    (state_q != StOffer),
    .quiet_o    (quiet)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    offer_d      = offer_q;
    idx_d        = idx_q;
    meas_value_d = meas_value_q;
    timeout_d    = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StLoad;
          meas_value_d = syn_data_i;
          timeout_d    = 1'b0;
        end
      end
      StLoad: begin
        state_d = StSettle;
        phase_d = '0;
      end
      StSettle: begin
        if (phase_q == PhaseW'(SettleCycles - 1)) begin
          state_d = StOffer;
          offer_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StOffer: begin
        if (offer_q != OfferW'(MaxOfferCycles)) offer_d = offer_q + 1'b1;
        // Convergence wins over a timeout landing on the same cycle.
        if (quiet) begin
          state_d = StStop;
        end else if (offer_q == OfferW'(MaxOfferCycles - 1)) begin
          state_d   = StStop;
          timeout_d = 1'b1;
        end
      end
      StStop: begin
        state_d = StDrain;
        phase_d = '0;
      end
      StDrain: begin
        if (phase_q == PhaseW'(DrainCycles - 1)) begin
          state_d = StReadout;
          idx_d   = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StReadout: begin
        if (beat) begin
          if (idx_q == IdxW'(NumPe - 1)) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Capture a PE value only when the beat index changes; hold it under stall.
    res_value_d = res_value_q;
    if (state_d == StReadout) begin
      if ((state_q != StReadout) || beat) begin
        res_value_d = match_i[idx_d*MatchValueWidth +: MatchValueWidth];
      end
    end else begin
      res_value_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      phase_q       <= '0;
      offer_q       <= '0;
      idx_q         <= '0;
      meas_value_q  <= '0;
      res_value_q   <= '0;
      timeout_q     <= 1'b0;
      syn_ready_q   <= 1'b1;
      meas_valid_q  <= 1'b0;
      start_offer_q <= 1'b0;
      stop_offer_q  <= 1'b0;
      res_valid_q   <= 1'b0;
      res_last_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      offer_q       <= offer_d;
      idx_q         <= idx_d;
      meas_value_q  <= meas_value_d;
      res_value_q   <= res_value_d;
      timeout_q     <= timeout_d;
      syn_ready_q   <= (state_d == StIdle);
      meas_valid_q  <= (state_d == StLoad);
      start_offer_q <= (state_q == StSettle) && (state_d == StOffer);
      stop_offer_q  <= (state_d == StStop);
      res_valid_q   <= (state_d == StReadout);
      res_last_q    <= (state_d == StReadout) && (idx_d == IdxW'(NumPe - 1));
      busy_q        <= (state_d != StIdle);
    end
  end

  assign syn_ready_o   = syn_ready_q;
  assign meas_value_o  = meas_value_q;
  assign meas_valid_o  = meas_valid_q;
  assign start_offer_o = start_offer_q;
  assign stop_offer_o  = stop_offer_q;
  assign res_valid_o   = res_valid_q;
  assign res_index_o   = idx_q;
  assign res_value_o   = res_value_q;
  assign res_last_o    = res_last_q;
  assign busy_o        = busy_q;
  assign timeout_err_o = timeout_q;

`ifdef ROUND_CYCLE_COUNTER_EN
  logic [31:0] rc_cnt_q, rc_cnt_d, round_cycles_q, round_cycles_d;

  // The accept cycle itself is not counted; the LOAD cycle is cycle 1.
  always_comb begin
    rc_cnt_d       = rc_cnt_q;
    round_cycles_d = round_cycles_q;
    if (accept) begin
      rc_cnt_d = 32'd1;
    end else if ((state_q != StIdle) && (rc_cnt_q != 32'hFFFF_FFFF)) begin
      rc_cnt_d = rc_cnt_q + 32'd1;
    end
    if ((state_q == StReadout) && beat && (idx_q == IdxW'(NumPe - 1))) begin
      round_cycles_d = rc_cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rc_cnt_q       <= '0;
      round_cycles_q <= '0;
    end else begin
      rc_cnt_q       <= rc_cnt_d;
      round_cycles_q <= round_cycles_d;
    end
  end

  assign round_cycles_o = round_cycles_q;
`endif

endmodule
